// File: rtl/key_press_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_press_gen
// Description : Emulates a mechanical active-low push-button. On request it
//               emits 'num' complete key presses, each consisting of a
//               contact-bounce burst on the falling edge, a stable-low hold,
//               a contact-bounce burst on the release, and a stable-high gap.
//
// Ports       : clk        - system clock (50 MHz nominal)
//               rst_n      - asynchronous active-low reset
//               start      - request pulse, honoured only while idle
//               num[3:0]   - number of presses to emit, sampled with start
//               key_out    - emulated active-low push-button line
//               busy       - high while a request is in progress
//               done       - single-cycle completion pulse
//               press_cnt  - presses completed in the current/last request
//
// Revision    : 1.0 - initial release
// ============================================================================
module key_press_gen #(
   parameter int BOUNCE_CYC = 50_000,     // cycles between bounce toggles
   parameter int BOUNCE_N   = 3,          // bounce pulse pairs per edge
   parameter int HOLD_CYC   = 2_500_000,  // stable-low hold time
   parameter int GAP_CYC    = 2_500_000   // stable-high time after release
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] num,
   output logic       key_out,
   output logic       busy,
   output logic       done,
   output logic [3:0] press_cnt
);

   // -------------------------------------------------------------------------
   // Derived constants
   // -------------------------------------------------------------------------
   // One bounce burst: 2*BOUNCE_N inversions spaced BOUNCE_CYC apart.
   localparam int c_BOUNCE_LEN = 2 * BOUNCE_N * BOUNCE_CYC;

   localparam int c_MAX_A   = (c_BOUNCE_LEN > HOLD_CYC) ? c_BOUNCE_LEN : HOLD_CYC;
   localparam int c_MAX_LEN = (c_MAX_A > GAP_CYC) ? c_MAX_A : GAP_CYC;

   // Phase timer is kept at a minimum of 25 bits so the default 50 ms phases
   // fit, and grows automatically if longer phases are configured.
   localparam int c_TMR_NEED = $clog2(c_MAX_LEN + 1);
   localparam int c_TMR_W    = (c_TMR_NEED > 25) ? c_TMR_NEED : 25;

   // Sub-counter spacing the bounce toggles.
   localparam int c_SUB_W = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;

   localparam logic [c_TMR_W-1:0] c_BOUNCE_LAST = c_TMR_W'(c_BOUNCE_LEN - 1);
   localparam logic [c_TMR_W-1:0] c_HOLD_LAST   = c_TMR_W'(HOLD_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_GAP_LAST    = c_TMR_W'(GAP_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_TMR_ONE     = c_TMR_W'(1);
   localparam logic [c_SUB_W-1:0] c_SUB_LAST    = c_SUB_W'(BOUNCE_CYC - 1);
   localparam logic [c_SUB_W-1:0] c_SUB_ONE     = c_SUB_W'(1);

   // -------------------------------------------------------------------------
   // State encoding
   // -------------------------------------------------------------------------
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      P_BOUNCE = 3'd1,
      HOLD     = 3'd2,
      R_BOUNCE = 3'd3,
      GAP      = 3'd4
   } state_t;

   // -------------------------------------------------------------------------
   // Registers and their next-state values
   // -------------------------------------------------------------------------
   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_TMR_W-1:0]   r_timer;
   logic [c_TMR_W-1:0]   w_timer_nxt;
   logic [c_SUB_W-1:0]   r_sub;
   logic [c_SUB_W-1:0]   w_sub_nxt;
   logic [3:0]           r_num;
   logic [3:0]           w_num_nxt;
   logic [3:0]           r_cnt;
   logic [3:0]           w_cnt_nxt;
   logic                 r_key;
   logic                 w_key_nxt;
   logic                 r_busy;
   logic                 w_busy_nxt;
   logic                 r_done;
   logic                 w_done_nxt;

   logic                 w_sub_wrap;
   logic                 w_bounce_end;

   assign w_sub_wrap   = (r_sub == c_SUB_LAST);
   assign w_bounce_end = (r_timer == c_BOUNCE_LAST);

   // -------------------------------------------------------------------------
   // State / output registers (asynchronous active-low reset)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_sub   <= '0;
         r_num   <= '0;
         r_cnt   <= '0;
         r_key   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_sub   <= w_sub_nxt;
         r_num   <= w_num_nxt;
         r_cnt   <= w_cnt_nxt;
         r_key   <= w_key_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer + c_TMR_ONE;
      w_sub_nxt   = '0;
      w_num_nxt   = r_num;
      w_cnt_nxt   = r_cnt;
      w_key_nxt   = r_key;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            w_timer_nxt = '0;
            w_key_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            if (start) begin
               w_cnt_nxt = '0;
               if (num != 4'd0) begin
                  // The line goes low on acceptance: this is the first
                  // half-period of the press bounce burst.
                  w_num_nxt   = num;
                  w_busy_nxt  = 1'b1;
                  w_key_nxt   = 1'b0;
                  w_state_nxt = P_BOUNCE;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end

         P_BOUNCE: begin
            w_sub_nxt = w_sub_wrap ? '0 : (r_sub + c_SUB_ONE);
            if (w_sub_wrap) begin
               w_key_nxt = ~r_key;
            end
            // The final inversion coincides with the burst end and leaves
            // the line low for HOLD.
            if (w_bounce_end) begin
               w_state_nxt = HOLD;
            end
         end

         HOLD: begin
            if (r_timer == c_HOLD_LAST) begin
               w_cnt_nxt   = r_cnt + 4'd1;
               w_key_nxt   = 1'b1;
               w_state_nxt = R_BOUNCE;
            end
         end

         R_BOUNCE: begin
            w_sub_nxt = w_sub_wrap ? '0 : (r_sub + c_SUB_ONE);
            if (w_sub_wrap) begin
               w_key_nxt = ~r_key;
            end
            // The final inversion leaves the line high for GAP.
            if (w_bounce_end) begin
               w_state_nxt = GAP;
            end
         end

         GAP: begin
            if (r_timer == c_GAP_LAST) begin
               if (r_cnt == r_num) begin
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_key_nxt   = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_key_nxt   = 1'b0;
                  w_state_nxt = P_BOUNCE;
               end
            end
         end

         default: begin
            w_key_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase

      // Every phase is timed from zero.
      if (w_state_nxt != r_state) begin
         w_timer_nxt = '0;
         w_sub_nxt   = '0;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign key_out   = r_key;
   assign busy      = r_busy;
   assign done      = r_done;
   assign press_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_key_press_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_press_gen
// Description : Self-checking bench for key_press_gen with a reference model
//               that derives the expected line level, busy, done and press
//               count from the cycle offset since the accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_press_gen;

   localparam int BC = 2;
   localparam int BN = 2;
   localparam int HC = 10;
   localparam int GC = 8;
   localparam int BL = 2 * BN * BC;              // one bounce burst
   localparam int T  = 4 * BN * BC + HC + GC;    // one full press

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] num   = 4'd0;
   logic       key_out;
   logic       busy;
   logic       done;
   logic [3:0] press_cnt;

   int n_chk   = 0;
   int n_fail  = 0;
   int exp_cnt = 0;

   key_press_gen #(
      .BOUNCE_CYC (BC),
      .BOUNCE_N   (BN),
      .HOLD_CYC   (HC),
      .GAP_CYC    (GC)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num       (num),
      .key_out   (key_out),
      .busy      (busy),
      .done      (done),
      .press_cnt (press_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected line level at offset o (0..T-1) within one press.
   function automatic logic key_at(input int o);
      if (o < BL)                return ((o / BC) % 2) ? 1'b1 : 1'b0;
      else if (o < BL + HC)      return 1'b0;
      else if (o < 2 * BL + HC)  return (((o - BL - HC) / BC) % 2) ? 1'b0 : 1'b1;
      else                       return 1'b1;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_key"},  32'(key_out),   32'd1);
      chk({tag, "_busy"}, 32'(busy),      32'd0);
      chk({tag, "_done"}, 32'(done),      32'd0);
      chk({tag, "_cnt"},  32'(press_cnt), 32'(exp_cnt));
   endtask

   task automatic idle_cycles(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         num = 4'($urandom_range(0, 15));
         check_idle(tag);
      end
   endtask

   // Check the cycle following edge k+j of a request for n presses.
   task automatic check_req(input int j, input int n);
      int o;
      int p;
      if (j < n * T) begin
         p = j / T;
         o = j % T;
         chk("req_key",  32'(key_out),   32'(key_at(o)));
         chk("req_busy", 32'(busy),      32'd1);
         chk("req_done", 32'(done),      32'd0);
         chk("req_cnt",  32'(press_cnt), 32'(p + ((o >= 2 * BL + HC - BL) ? 1 : 0)));
      end else if (j == n * T) begin
         chk("end_done", 32'(done),      32'd1);
         chk("end_busy", 32'(busy),      32'd0);
         chk("end_key",  32'(key_out),   32'd1);
         chk("end_cnt",  32'(press_cnt), 32'(n));
      end else begin
         exp_cnt = n;
         check_idle("post");
      end
   endtask

   // Issue a request and follow it cycle by cycle. noise_at >= 0 pulses
   // start (num=5) after that cycle; stop_at >= 0 returns early there.
   task automatic run_req(input int n, input int noise_at, input int stop_at);
      @(negedge clk);
      start = 1'b1;
      num   = 4'(n);
      @(negedge clk);
      start = 1'b0;
      num   = 4'($urandom_range(0, 15));
      for (int j = 0; j <= n * T + 1; j++) begin
         if (j > 0) @(negedge clk);
         check_req(j, n);
         start = 1'b0;
         if (stop_at >= 0 && j == stop_at) return;
         if (j == noise_at) begin
            start = 1'b1;
            num   = 4'd5;
         end
      end
      exp_cnt = n;
   endtask

   initial begin
      int n;
      int na;

      // Reset and idle
      repeat (3) @(negedge clk);
      #1;
      check_idle("rst");
      rst_n = 1'b1;
      idle_cycles(20, "idle");

      // Single press: exact waveform and done timing
      run_req(1, -1, -1);
      idle_cycles(3, "gap1");

      // Three presses
      run_req(3, -1, -1);
      idle_cycles(2, "gap3");

      // num = 0: immediate done, no line activity, count cleared
      run_req(0, -1, -1);
      idle_cycles(2, "gap0");

      // Start with num=5 during a request must be ignored
      run_req(2, 40, -1);
      idle_cycles(2, "gapn");

      // Reset in HOLD of the second press
      run_req(2, -1, T + BL + 3);
      rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      check_idle("abort");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("inrst");
      end
      rst_n = 1'b1;
      idle_cycles(5, "postrst");
      run_req(1, -1, -1);

      // Randomized requests with random gaps and stray start pulses
      for (int r = 0; r < 5; r++) begin
         idle_cycles($urandom_range(1, 6), "rgap");
         n  = $urandom_range(0, 4);
         na = (n > 0) ? $urandom_range(1, n * T - 3) : -1;
         run_req(n, na, -1);
      end
      idle_cycles(3, "tail");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
